// File: rtl/instruction_loader.sv
// Length-prefixed byte-stream loader that writes a program image into instruction memory
// and holds the CPU in reset until the image is complete. Optional: LOADER_CHECKSUM_EN.
module instruction_loader #(
    parameter int unsigned MEM_BYTES = 132,
    parameter logic [63:0] BASE_ADDR = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        In_Valid,
    input  logic [7:0]  In_Data,
    output logic        In_Ready,
    output logic        Mem_Write_En,
    output logic [63:0] Mem_Write_Address,
    output logic [7:0]  Mem_Write_Data,
    output logic        Cpu_Hold,
    output logic        Load_Done,
    output logic        Load_Error,
    output logic [15:0] Bytes_Loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [63:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;
    logic        wr_en_q, wr_en_d;
    logic [63:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        done_q, done_d;
    logic        hold_q, hold_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
`endif

    logic        xfer;
    logic [15:0] cnt_inc;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Offset from the base keeps the range test correct even when the address wraps.
    function automatic logic in_range(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE_ADDR;
        return off < 64'(MEM_BYTES);
    endfunction

    assign xfer    = In_Valid && ready_q;
    assign cnt_inc = sat_inc16(cnt_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            hold_q    <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            hold_q    <= hold_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (Start) state_d = S_LEN_LO;
            S_LEN_LO:       if (xfer) state_d = S_LEN_HI;
            S_LEN_HI: begin
                if (xfer) state_d = ({In_Data, len_q[7:0]} == 16'd0) ? S_DONE : S_DATA;
            end
            S_DATA: begin
                if (xfer && (cnt_inc == len_q)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:         if (xfer) state_d = S_DONE;
`endif
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        len_d     = len_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d     = xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    err_d  = 1'b0;
                    cnt_d  = '0;
                    addr_d = BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                    xor_d  = '0;
`endif
                end
            end
            S_LEN_LO: if (xfer) len_d[7:0] = In_Data;
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = In_Data;
                    if (len_q[1:0] != 2'b00) err_d = 1'b1;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    cnt_d  = cnt_inc;
                    addr_d = addr_q + 64'd1;
`ifdef LOADER_CHECKSUM_EN
                    xor_d  = xor_q ^ In_Data;
`endif
                    // Out-of-range bytes are still consumed so the stream drains.
                    if (in_range(addr_q)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = In_Data;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: if (xfer && (In_Data != xor_q)) err_d = 1'b1;
`endif
            default: ;
        endcase

        ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                  (state_d == S_DATA)   || (state_d == S_CSUM);
        // Done rises one cycle after DONE is entered, i.e. after the final write strobe.
        done_d  = (state_q == S_DONE) && (state_d == S_DONE);
`ifdef LOADER_CHECKSUM_EN
        hold_d  = !(done_d && !err_q);
`else
        hold_d  = !done_d;
`endif
    end

    assign In_Ready          = ready_q;
    assign Mem_Write_En      = wr_en_q;
    assign Mem_Write_Address = wr_addr_q;
    assign Mem_Write_Data    = wr_data_q;
    assign Cpu_Hold          = hold_q;
    assign Load_Done         = done_q;
    assign Load_Error        = err_q;
    assign Bytes_Loaded      = cnt_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: table of load vectors plus hand-written corner sequences.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic        In_Valid;
    logic [7:0]  In_Data;
    logic        In_Ready;
    logic        Mem_Write_En;
    logic [63:0] Mem_Write_Address;
    logic [7:0]  Mem_Write_Data;
    logic        Cpu_Hold;
    logic        Load_Done;
    logic        Load_Error;
    logic [15:0] Bytes_Loaded;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pay [0:255];
    logic [7:0] exp_data [0:255];
    int         exp_n  = 0;
    int         wr_idx = 0;

    typedef struct {
        logic [15:0] len;
        logic [63:0] pay;
        int          gap;
        logic        err;
    } vec_t;

    vec_t tbl [5];

    instruction_loader dut (
        .clk              (clk),
        .reset            (reset),
        .Start            (Start),
        .In_Valid         (In_Valid),
        .In_Data          (In_Data),
        .In_Ready         (In_Ready),
        .Mem_Write_En     (Mem_Write_En),
        .Mem_Write_Address(Mem_Write_Address),
        .Mem_Write_Data   (Mem_Write_Data),
        .Cpu_Hold         (Cpu_Hold),
        .Load_Done        (Load_Done),
        .Load_Error       (Load_Error),
        .Bytes_Loaded     (Bytes_Loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Write-strobe scoreboard: every strobe must match the next expected byte.
    always @(negedge clk) begin
        if (reset === 1'b1 && Mem_Write_En === 1'b1) begin
            if (wr_idx >= exp_n) begin
                check("extra_strobe", 64'(wr_idx), 64'(exp_n));
            end else begin
                check("wr_addr", Mem_Write_Address, 64'(wr_idx));
                check("wr_data", 64'(Mem_Write_Data), 64'(exp_data[wr_idx]));
            end
            wr_idx++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic last);
        int t = 0;
        In_Data  = b;
        In_Valid = 1'b1;
        while (In_Ready !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        if (In_Ready !== 1'b1) begin
            check("in_ready_wait", 64'(In_Ready), 64'd1);
            In_Valid = 1'b0;
            return;
        end
        tick();
        In_Valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            if (!last) check("ready_in_gap", 64'(In_Ready), 64'd1);
            tick();
        end
    endtask

    task automatic set_expect(input int n);
        for (int i = 0; i < 256; i++) exp_data[i] = pay[i];
        exp_n  = (n > 132) ? 132 : n;
        wr_idx = 0;
    endtask

    task automatic finish_csum(input logic [7:0] b, input int gap);
`ifdef LOADER_CHECKSUM_EN
        send_byte(b, gap, 1'b1);
`else
        if (b !== b) $display("unreachable");
        if (gap < 0) $display("unreachable");
`endif
    endtask

    task automatic run_load(input logic [15:0] len, input int gap, input logic bad_csum);
        int n;
        logic [7:0] x;
        logic csum_mode;
        n = int'(len);
        x = 8'h00;
`ifdef LOADER_CHECKSUM_EN
        csum_mode = 1'b1;
`else
        csum_mode = 1'b0;
`endif
        set_expect(n);
        do_start();
        check("ready_after_start", 64'(In_Ready), 64'd1);
        send_byte(len[7:0], gap, 1'b0);
        send_byte(len[15:8], gap, n == 0);
        for (int i = 0; i < n; i++) begin
            x ^= pay[i];
            send_byte(pay[i], gap, (i == n - 1) && !csum_mode);
        end
        if (n != 0) finish_csum(bad_csum ? 8'h55 : x, gap);
        tick();
        tick();
    endtask

    task automatic post_check(input logic [15:0] len, input logic exp_err);
        logic exp_hold;
`ifdef LOADER_CHECKSUM_EN
        exp_hold = exp_err;
`else
        exp_hold = 1'b0;
`endif
        check("strobe_count", 64'(wr_idx), 64'(exp_n));
        check("load_error", 64'(Load_Error), 64'(exp_err));
        check("bytes_loaded", 64'(Bytes_Loaded), 64'(len));
        check("load_done", 64'(Load_Done), 64'd1);
        check("cpu_hold", 64'(Cpu_Hold), 64'(exp_hold));
        check("ready_in_done", 64'(In_Ready), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 64'(In_Ready), 64'd0);
        check({tag, "_wen"}, 64'(Mem_Write_En), 64'd0);
        check({tag, "_waddr"}, Mem_Write_Address, 64'd0);
        check({tag, "_wdata"}, 64'(Mem_Write_Data), 64'd0);
        check({tag, "_hold"}, 64'(Cpu_Hold), 64'd1);
        check({tag, "_done"}, 64'(Load_Done), 64'd0);
        check({tag, "_err"}, 64'(Load_Error), 64'd0);
        check({tag, "_bytes"}, 64'(Bytes_Loaded), 64'd0);
    endtask

    task automatic load_vec(input int k);
        for (int i = 0; i < 8; i++) pay[i] = tbl[k].pay[8*i +: 8];
    endtask

    initial begin
        reset    = 1'b0;
        Start    = 1'b0;
        In_Valid = 1'b0;
        In_Data  = 8'h00;

        tbl[0] = '{16'd4, 64'h0000_0000_0190_0293, 0, 1'b0};
        tbl[1] = '{16'd4, 64'h0000_0000_0190_0293, 3, 1'b0};
        tbl[2] = '{16'd0, 64'h0, 0, 1'b0};
        tbl[3] = '{16'd3, 64'h0000_0000_00cc_bbaa, 1, 1'b1};
        tbl[4] = '{16'd8, 64'h8877_6655_4433_2211, 0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        reset = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) begin
            load_vec(k);
            run_load(tbl[k].len, tbl[k].gap, 1'b0);
            post_check(tbl[k].len, tbl[k].err);
        end

        // Image larger than memory: last four bytes drain without a strobe.
        for (int i = 0; i < 136; i++) pay[i] = 8'(i) ^ 8'h5a;
        run_load(16'd136, 0, 1'b0);
        post_check(16'd136, 1'b1);

`ifndef LOADER_CHECKSUM_EN
        // Done/hold rise one cycle after the final strobe; Start from DONE re-holds next cycle.
        load_vec(0);
        set_expect(4);
        do_start();
        send_byte(8'h04, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h93, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h90, 0, 1'b0);
        In_Data  = 8'h01;
        In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        check("last_strobe", 64'(Mem_Write_En), 64'd1);
        check("done_not_yet", 64'(Load_Done), 64'd0);
        check("hold_not_yet", 64'(Cpu_Hold), 64'd1);
        tick();
        check("done_rise", 64'(Load_Done), 64'd1);
        check("hold_fall", 64'(Cpu_Hold), 64'd0);
        check("strobe_single", 64'(Mem_Write_En), 64'd0);
        repeat (3) tick();
        check("done_held", 64'(Load_Done), 64'd1);
        do_start();
        check("restart_hold", 64'(Cpu_Hold), 64'd1);
        check("restart_done", 64'(Load_Done), 64'd0);
        check("restart_ready", 64'(In_Ready), 64'd1);
        set_expect(0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b1);
        tick();
        tick();
        post_check(16'd0, 1'b0);
`endif

        // Start pulsed during DATA must be ignored.
        load_vec(0);
        set_expect(4);
        do_start();
        send_byte(8'h04, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h93, 0, 1'b0);
        Start = 1'b1;
        send_byte(8'h02, 0, 1'b0);
        Start = 1'b0;
        send_byte(8'h90, 0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h01, 0, 1'b0);
        finish_csum(8'h00, 0);
`else
        send_byte(8'h01, 0, 1'b1);
`endif
        tick();
        tick();
        post_check(16'd4, 1'b0);

        // Reset during DATA aborts at once; a fresh load then succeeds.
        load_vec(4);
        set_expect(8);
        do_start();
        send_byte(8'h08, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(pay[0], 0, 1'b0);
        send_byte(pay[1], 0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check_reset_values("mid_rst");
        tick();
        tick();
        reset = 1'b1;
        check("no_strobe_after_rst", 64'(wr_idx), 64'd1);
        tick();
        load_vec(0);
        run_load(16'd4, 0, 1'b0);
        post_check(16'd4, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        load_vec(0);
        run_load(16'd4, 0, 1'b1);
        post_check(16'd4, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
